// File: rtl/fp_leaf_sum_accumulator_pkg.sv
// Shared types and constants for the leaf-score sum accumulator.
// Words use the FloPoCo 34-bit layout: exc[33:32], sign[31], exp[30:23], frac[22:0].
package fp_leaf_sum_accumulator_pkg;

  typedef logic [33:0] fpWord_t;

  localparam fpWord_t FP_ZERO = 34'h0;
  localparam int      ADD_LAT = 2;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DRAIN   = 2'd1,
    COMBINE = 2'd2,
    OUT     = 2'd3
  } state_t;

endpackage

// File: rtl/FPAdder_8_23_uid2_l2.sv
// Two-cycle FloPoCo single-precision adder (round to nearest even, no subnormals).
// A sum issued with X/Y in cycle t is presented on R during cycle t+2.
module FPAdder_8_23_uid2_l2 (
  input  logic        clk,
  input  logic        seq_stall,
  input  logic [33:0] X,
  input  logic [33:0] Y,
  output logic [33:0] R
);

  logic [33:0] sumComb, stage1Reg, stage2Reg;
  logic [33:0] a, b, normalRes;
  logic [7:0]  expDiff;
  logic [4:0]  shAmt, lz;
  logic [26:0] mA, mBfull, mBsh, normMant;
  logic [27:0] sumMant;
  logic [9:0]  expNorm, expFinal;
  logic [24:0] rounded;
  logic [22:0] fracFinal;
  logic        effSub, bSticky, roundUp;

  always_comb begin
    // Order operands by magnitude so the result sign is always a's sign.
    a = (Y[30:0] > X[30:0]) ? Y : X;
    b = (Y[30:0] > X[30:0]) ? X : Y;
    expDiff = a[30:23] - b[30:23];
    shAmt   = (expDiff > 8'd27) ? 5'd27 : expDiff[4:0];
    mA      = {1'b1, a[22:0], 3'b000};
    mBfull  = {1'b1, b[22:0], 3'b000};
    bSticky = |(mBfull & ((27'd1 << shAmt) - 27'd1));
    mBsh    = (mBfull >> shAmt) | {26'b0, bSticky};
    effSub  = a[31] ^ b[31];
    sumMant = effSub ? ({1'b0, mA} - {1'b0, mBsh}) : ({1'b0, mA} + {1'b0, mBsh});

    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sumMant[i]) lz = 5'(26 - i);
    end

    if (sumMant[27]) begin
      normMant = {sumMant[27:2], sumMant[1] | sumMant[0]};
      expNorm  = {2'b00, a[30:23]} + 10'd1;
    end else begin
      normMant = sumMant[26:0] << lz;
      expNorm  = {2'b00, a[30:23]} - {5'b0, lz};
    end

    roundUp = normMant[2] & (normMant[1] | normMant[0] | normMant[3]);
    rounded = {1'b0, normMant[26:3]} + {24'b0, roundUp};
    if (rounded[24]) begin
      expFinal  = expNorm + 10'd1;
      fracFinal = 23'd0;
    end else begin
      expFinal  = expNorm;
      fracFinal = rounded[22:0];
    end

    // Exponent is two's complement here: bit 9 set means underflow, flushed to zero.
    if (sumMant == 28'd0)
      normalRes = 34'h0;
    else if (expFinal[9] || expFinal == 10'd0)
      normalRes = {2'b00, a[31], 31'h0};
    else if (expFinal >= 10'd255)
      normalRes = {2'b10, a[31], 31'h0};
    else
      normalRes = {2'b01, a[31], expFinal[7:0], fracFinal};

    if (X[33:32] == 2'b11 || Y[33:32] == 2'b11 ||
        (X[33:32] == 2'b10 && Y[33:32] == 2'b10 && X[31] != Y[31]))
      sumComb = {2'b11, 32'h0};
    else if (X[33:32] == 2'b10)
      sumComb = X;
    else if (Y[33:32] == 2'b10)
      sumComb = Y;
    else if (X[33:32] == 2'b00 && Y[33:32] == 2'b00)
      sumComb = {2'b00, X[31] & Y[31], 31'h0};
    else if (X[33:32] == 2'b00)
      sumComb = Y;
    else if (Y[33:32] == 2'b00)
      sumComb = X;
    else
      sumComb = normalRes;
  end

  always_ff @(posedge clk) begin
    if (!seq_stall) begin
      stage1Reg <= sumComb;
      stage2Reg <= stage1Reg;
    end
  end

  assign R = stage2Reg;

endmodule

// File: rtl/fp_leaf_sum_accumulator.sv
// Reduces each packet of FloPoCo leaf scores to one sum, using two interleaved
// partial-sum lanes to cover the adder latency and a final lane combine.
module fp_leaf_sum_accumulator
  import fp_leaf_sum_accumulator_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [33:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [33:0]      m_data,
  output logic [CNT_W-1:0] m_count
);

  state_t           stateReg, stateNext;
  fpWord_t          laneReg [2];
  logic [1:0]       busyReg;
  logic             ptrReg;
  logic [CNT_W-1:0] countReg;

  // Tag pipe tracks which lane (or the combine) each in-flight add belongs to.
  logic    tag1Valid, tag1Lane, tag1Comb;
  logic    tag2Valid, tag2Lane, tag2Comb;
  logic    issueValid, issueLane, issueComb;
  logic    accept, retHit;
  fpWord_t addX, addY, addR;

  FPAdder_8_23_uid2_l2 adder (
    .clk       (clk),
    .seq_stall (1'b0),
    .X         (addX),
    .Y         (addY),
    .R         (addR)
  );

  always_comb begin
    stateNext  = stateReg;
    s_ready    = 1'b0;
    accept     = 1'b0;
    issueValid = 1'b0;
    issueLane  = ptrReg;
    issueComb  = 1'b0;
    addX       = s_data;
    addY       = laneReg[ptrReg];
    retHit     = tag2Valid && !tag2Comb && (tag2Lane == ptrReg);
    case (stateReg)
      ACCUM: begin
        s_ready    = !busyReg[ptrReg] || retHit;
        accept     = s_valid && s_ready;
        issueValid = accept;
        if (retHit) addY = addR;
        if (accept && s_last) stateNext = DRAIN;
      end
      DRAIN: begin
        if (!tag1Valid && !tag2Valid) begin
          issueValid = 1'b1;
          issueComb  = 1'b1;
          addX       = laneReg[0];
          addY       = laneReg[1];
          stateNext  = COMBINE;
        end
      end
      COMBINE: begin
        if (tag2Valid && tag2Comb) stateNext = OUT;
      end
      OUT: begin
        if (m_valid && m_ready) stateNext = ACCUM;
      end
      default: stateNext = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= ACCUM;
      laneReg[0] <= FP_ZERO;
      laneReg[1] <= FP_ZERO;
      busyReg    <= 2'b00;
      ptrReg     <= 1'b0;
      countReg   <= '0;
      tag1Valid  <= 1'b0;
      tag1Lane   <= 1'b0;
      tag1Comb   <= 1'b0;
      tag2Valid  <= 1'b0;
      tag2Lane   <= 1'b0;
      tag2Comb   <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= FP_ZERO;
      m_count    <= '0;
    end else begin
      stateReg  <= stateNext;
      tag1Valid <= issueValid;
      tag1Lane  <= issueLane;
      tag1Comb  <= issueComb;
      tag2Valid <= tag1Valid;
      tag2Lane  <= tag1Lane;
      tag2Comb  <= tag1Comb;
      if (tag2Valid && !tag2Comb) begin
        laneReg[tag2Lane] <= addR;
        busyReg[tag2Lane] <= 1'b0;
      end
      // A new issue to the lane that is returning keeps it busy.
      if (accept) begin
        busyReg[ptrReg] <= 1'b1;
        ptrReg          <= ~ptrReg;
        countReg        <= countReg + CNT_W'(1);
      end
      if (stateReg == COMBINE && tag2Valid && tag2Comb) begin
        m_data  <= addR;
        m_count <= countReg;
        m_valid <= 1'b1;
      end
      if (stateReg == OUT && m_valid && m_ready) begin
        m_valid    <= 1'b0;
        laneReg[0] <= FP_ZERO;
        laneReg[1] <= FP_ZERO;
        countReg   <= '0;
        ptrReg     <= 1'b0;
      end
    end
  end

endmodule
